// File: rtl/control_sequencer.sv
// control_sequencer: hardwired T-step control unit for the single-bus datapath
module control_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        Cout,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Yin,
  output logic        Zin,
  output logic        CONin,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic [3:0]  step
);
  typedef enum logic [3:0] {
    T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3,
    T4 = 4'd4, T5 = 4'd5, T6 = 4'd6, T7 = 4'd7, HALT = 4'd15
  } state_t;
  state_t state, nxt;
  logic [4:0] op;
  logic is_alu, is_imm, is_ldi, is_ld, is_st, is_br, is_jr, is_halt;
  logic rb, ba, long_op;
  logic unused_ir;
  assign op        = ir[31:27];
  assign unused_ir = ^ir[26:0];
  assign is_alu  = op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110};
  assign is_imm  = op inside {5'b01100, 5'b01101, 5'b01110};
  assign is_ldi  = op == 5'b00001;
  assign is_ld   = op == 5'b00000;
  assign is_st   = op == 5'b00010;
  assign is_br   = op == 5'b10010;
  assign is_jr   = op == 5'b10011;
  assign is_halt = op == 5'b11011;
  // rb: operand from Rb; ba: base-address path shared by ldi/ld/st
  assign rb      = is_alu | is_imm;
  assign ba      = is_ldi | is_ld | is_st;
  assign long_op = rb | ba | is_br | is_jr;
  assign step    = state;
  assign run     = state != HALT;
  always_ff @(posedge clk)
    state <= reset ? T0 : nxt;
  always_comb begin
    nxt = state;
    case (state)
      T0:      nxt = T1;
      T1:      nxt = mem_ready ? T2 : T1;
      T2:      nxt = is_halt ? HALT : long_op ? T3 : T0;
      T3:      nxt = is_jr ? T0 : T4;
      T4:      nxt = T5;
      T5:      nxt = (is_ld | is_st | is_br) ? T6 : T0;
      T6:      nxt = is_ld ? (mem_ready ? T7 : T6) : is_st ? T7 : T0;
      T7:      nxt = (is_st && !mem_ready) ? T7 : T0;
      default: nxt = HALT;
    endcase
  end
  always_comb begin
    PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; Cout = 1'b0;
    PCin = 1'b0; IRin = 1'b0; MARin = 1'b0; MDRin = 1'b0;
    Yin = 1'b0; Zin = 1'b0; CONin = 1'b0; IncPC = 1'b0;
    Read = 1'b0; Write = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    alu_op = 5'b00000;
    if (!reset)
      case (state)
        T0: begin
          PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        end
        T1: begin
          Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        end
        T2: begin
          MDRout = 1'b1; IRin = 1'b1;
        end
        T3: begin
          Grb   = rb | ba;
          Yin   = rb | ba;
          BAout = ba;
          Gra   = is_br | is_jr;
          Rout  = rb | is_br | is_jr;
          CONin = is_br;
          PCin  = is_jr;
        end
        T4: begin
          Grc    = is_alu;
          Rout   = is_alu;
          Cout   = is_imm | ba;
          Zin    = rb | ba;
          alu_op = rb ? op : ba ? 5'b00011 : 5'b00000;
          PCout  = is_br;
          Yin    = is_br;
        end
        T5: begin
          Zlowout = rb | ba;
          Gra     = rb | is_ldi;
          Rin     = rb | is_ldi;
          MARin   = is_ld | is_st;
          Cout    = is_br;
          Zin     = is_br;
          alu_op  = is_br ? 5'b00011 : 5'b00000;
        end
        T6: begin
          Read    = is_ld;
          MDRin   = is_ld | is_st;
          Gra     = is_st;
          Rout    = is_st;
          Zlowout = is_br;
          PCin    = is_br & con_ff;
        end
        T7: begin
          MDRout = is_ld;
          Gra    = is_ld;
          Rin    = is_ld;
          Write  = is_st;
        end
        default: ;
      endcase
  end
endmodule
